mpu_violation_handler: RTL and testbench
========================================

Name: mpu_violation_handler

Overview:
Consumes the MPU's per-access violation verdict and turns it into system response. It latches the first faulting access, counts violations, raises an interrupt to machine-mode firmware, and enforces a sticky lockout after repeated violations. Sits between the MPU and the CPU/interrupt logic. It exposes a small register window that only machine mode can clear.

Parameters:
LOCK_THRESHOLD, 8, violations that trigger permanent lockout; 0 disables lockout
CNT_W, 8, width of the saturating violation counter

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
acc_valid  input  1  a CPU memory access is presented this cycle
violation  input  1  MPU verdict for the current access
acc_addr  input  32  address of the current access
acc_write  input  1  current access is a write
acc_exec  input  1  current access is an instruction fetch
acc_priv  input  1  CPU in machine mode during the access
reg_sel  input  1  register window access strobe
reg_we  input  1  1 = write, 0 = read
reg_off  input  4  byte offset: 0x0, 0x4, 0x8 or 0xC
reg_wdata  input  32  write data
reg_priv  input  1  register access issued in machine mode
reg_rdata  output  32  read data, valid 1 cycle after a read strobe
irq  output  1  violation interrupt, level
lockout  output  1  sticky lockout; the SoC gates unlock actuation and peripherals with it

Behaviour:
- Event definition: ev = acc_valid & violation. Nothing is recorded when acc_valid = 0.
- Reset values: all outputs 0, state IDLE, counter 0, fault registers 0, overflow flag 0.
- State IDLE:
  - On ev, capture fault_addr = acc_addr and fault_info = {acc_priv, acc_exec, acc_write}.
  - Increment the counter, set irq the next cycle, and go to PENDING.
  - If LOCK_THRESHOLD != 0 and the new count >= LOCK_THRESHOLD, go to LOCKED instead.
- State PENDING:
  - Further ev events increment the counter and set overflow = 1.
  - Fault registers are NOT overwritten; the first fault is preserved.
  - The threshold check applies on every increment, and reaching the threshold moves to LOCKED.
- Clearing PENDING:
  - Clear is a privileged write (reg_sel & reg_we & reg_priv) to offset 0x0 with wdata[0] = 1 (write-1-to-clear).
  - Clear moves to IDLE and drops irq and overflow. The counter is not cleared.
- Clear and ev in the same cycle: the event wins. Capture the new fault, stay PENDING, keep irq = 1, overflow = 0.
- State LOCKED:
  - irq = 1 and lockout = 1, both held.
  - All clears are ignored. The counter keeps counting, saturating.
  - Fault registers are frozen. Only rst_n exits LOCKED.
- Counter saturates at 2^CNT_W - 1 and never wraps.
- Register map (reads are allowed in any privilege mode):
  - 0x0 STATUS = {29'b0, locked, overflow, pending}
  - 0x4 FAULT_ADDR
  - 0x8 FAULT_INFO = {29'b0, priv, exec, write}
  - 0xC COUNT, zero-extended
- Register access rules:
  - Unaligned or unmapped offsets read 0.
  - Writes to offsets other than 0x0 are ignored.
  - Unprivileged writes are ignored and have no side effect.
- Read timing: reg_rdata is registered, so data appears 1 cycle after the read strobe. reg_rdata returns to 0 in cycles with no read.
- A read issued in the same cycle as an ev returns the pre-event register state.
- Reset mid-operation: asserting rst_n = 0 immediately forces the reset values (asynchronous). Lockout is released only by reset.

Test Plan:
1. Single violation: ev with addr 0x40000010, acc_write = 1, acc_priv = 0. Next cycle irq = 1. STATUS reads 0x1, FAULT_ADDR reads 0x40000010, FAULT_INFO reads 0x1, COUNT reads 1.
2. Second fault while PENDING: ev at 0x00000004. FAULT_ADDR stays 0x40000010, STATUS = 0x3, COUNT = 2. A privileged write of 0x1 to 0x0 gives irq = 0, STATUS = 0x0, COUNT = 2.
3. Unprivileged clear: write 0x1 to 0x0 with reg_priv = 0 while PENDING. irq stays 1 and STATUS is unchanged.
4. Simultaneous clear and ev at 0x00010020. Result: state PENDING, FAULT_ADDR = 0x00010020, overflow = 0, irq = 1.
5. Lockout with LOCK_THRESHOLD = 8: after the 8th ev, lockout = 1 and STATUS = 0x4 | pending bits. A privileged clear leaves lockout = 1. Asserting rst_n = 0 mid-cycle clears all outputs at once.
6. Saturation with CNT_W = 4 and LOCK_THRESHOLD = 0: 20 ev events give COUNT = 15 and lockout remains 0. acc_valid = 0 with violation = 1 produces no count change.

Source files
------------

// File: rtl/mpu_violation_handler.sv
// rtl/mpu_violation_handler.sv - MPU violation latch, counter, interrupt and sticky lockout
module mpu_violation_handler #(
  parameter int LOCK_THRESHOLD = 8,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        acc_valid,
  input  logic        violation,
  input  logic [31:0] acc_addr,
  input  logic        acc_write,
  input  logic        acc_exec,
  input  logic        acc_priv,
  input  logic        reg_sel,
  input  logic        reg_we,
  input  logic [3:0]  reg_off,
  input  logic [31:0] reg_wdata,
  input  logic        reg_priv,
  output logic [31:0] reg_rdata,
  output logic        irq,
  output logic        lockout
);

  typedef enum logic [1:0] {IDLE, PENDING, LOCKED} state_t;

  localparam logic [31:0] THR = LOCK_THRESHOLD;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      fault_addr;
  logic [2:0]       fault_info;
  logic             overflow;
  logic             ev, clr, hit, capture;
  logic [31:0]      rd_mux;

  assign ev      = acc_valid & violation;
  assign clr     = reg_sel & reg_we & reg_priv & (reg_off == 4'h0) & reg_wdata[0];
  assign cnt_nxt = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  assign hit     = (THR != 32'd0) && (32'(cnt_nxt) >= THR);
  // A clear coinciding with an event re-arms on the new fault rather than dropping it
  assign capture = ev & ((state == IDLE) | ((state == PENDING) & clr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ev) state_nxt = hit ? LOCKED : PENDING;
      PENDING: begin
        if (ev)       state_nxt = hit ? LOCKED : PENDING;
        else if (clr) state_nxt = IDLE;
      end
      LOCKED:  state_nxt = LOCKED;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    irq     = (state != IDLE);
    lockout = (state == LOCKED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      fault_addr <= '0;
      fault_info <= '0;
      overflow   <= 1'b0;
    end else begin
      if (ev) cnt <= cnt_nxt;
      if (capture) begin
        fault_addr <= acc_addr;
        fault_info <= {acc_priv, acc_exec, acc_write};
      end
      if (state == PENDING) begin
        if (ev)       overflow <= ~clr;
        else if (clr) overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (reg_off)
      4'h0: rd_mux = {29'd0, state == LOCKED, overflow, state != IDLE};
      4'h4: rd_mux = fault_addr;
      4'h8: rd_mux = {29'd0, fault_info};
      4'hC: rd_mux = 32'(cnt);
      default: rd_mux = 32'd0;
    endcase
  end

  // Registered read port samples pre-event state; idle cycles return 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  reg_rdata <= 32'd0;
    else if (reg_sel && !reg_we) reg_rdata <= rd_mux;
    else                         reg_rdata <= 32'd0;
  end

endmodule

// File: tb/tb_mpu_violation_handler.sv
// tb/tb_mpu_violation_handler.sv - directed self-checking bench for mpu_violation_handler
module tb_mpu_violation_handler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        acc_valid, violation, acc_write, acc_exec, acc_priv;
  logic [31:0] acc_addr;
  logic        reg_sel, reg_we, reg_priv;
  logic [3:0]  reg_off;
  logic [31:0] reg_wdata;
  logic [31:0] rdata0, rdata1;
  logic        irq0, irq1, lock0, lock1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mpu_violation_handler #(.LOCK_THRESHOLD(8), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .acc_valid(acc_valid), .violation(violation),
    .acc_addr(acc_addr), .acc_write(acc_write), .acc_exec(acc_exec), .acc_priv(acc_priv),
    .reg_sel(reg_sel), .reg_we(reg_we), .reg_off(reg_off), .reg_wdata(reg_wdata),
    .reg_priv(reg_priv), .reg_rdata(rdata0), .irq(irq0), .lockout(lock0)
  );

  mpu_violation_handler #(.LOCK_THRESHOLD(0), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .acc_valid(acc_valid), .violation(violation),
    .acc_addr(acc_addr), .acc_write(acc_write), .acc_exec(acc_exec), .acc_priv(acc_priv),
    .reg_sel(reg_sel), .reg_we(reg_we), .reg_off(reg_off), .reg_wdata(reg_wdata),
    .reg_priv(reg_priv), .reg_rdata(rdata1), .irq(irq1), .lockout(lock1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    acc_valid = 0; violation = 0; acc_addr = 0; acc_write = 0; acc_exec = 0; acc_priv = 0;
    reg_sel = 0; reg_we = 0; reg_off = 0; reg_wdata = 0; reg_priv = 0;
  endtask

  task automatic set_ev(input logic [31:0] a, input logic w, input logic x, input logic p);
    acc_valid = 1; violation = 1; acc_addr = a; acc_write = w; acc_exec = x; acc_priv = p;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic ev(input logic [31:0] a, input logic w, input logic x, input logic p);
    @(negedge clk); set_ev(a, w, x, p); step();
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic p);
    @(negedge clk);
    reg_sel = 1; reg_we = 1; reg_off = off; reg_wdata = d; reg_priv = p;
    step();
  endtask

  task automatic rd(input int which, input logic [3:0] off, input logic [31:0] exp, input string tag);
    @(negedge clk);
    reg_sel = 1; reg_we = 0; reg_off = off; reg_priv = 0;
    step();
    check(tag, (which == 0) ? rdata0 : rdata1, exp);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_irq", {31'd0, irq0}, 32'd0);
    check("reset_lockout", {31'd0, lock0}, 32'd0);
    check("reset_rdata", rdata0, 32'd0);
    @(negedge clk); rst_n = 1;
    rd(0, 4'h0, 32'h0, "reset_status");

    // single violation
    ev(32'h4000_0010, 1, 0, 0);
    check("t1_irq", {31'd0, irq0}, 32'd1);
    rd(0, 4'h0, 32'h1, "t1_status");
    rd(0, 4'h4, 32'h4000_0010, "t1_addr");
    rd(0, 4'h8, 32'h1, "t1_info");
    rd(0, 4'hC, 32'd1, "t1_count");
    rd(0, 4'h2, 32'h0, "unaligned_rd");
    rd(0, 4'hE, 32'h0, "unmapped_rd");

    // second fault while pending, then privileged clear
    ev(32'h0000_0004, 0, 0, 0);
    rd(0, 4'h4, 32'h4000_0010, "t2_addr_kept");
    rd(0, 4'h0, 32'h3, "t2_status");
    rd(0, 4'hC, 32'd2, "t2_count");
    wr(4'h4, 32'h1, 1);
    check("t2_off4_wr_ignored", {31'd0, irq0}, 32'd1);
    wr(4'h0, 32'h1, 1);
    check("t2_clr_irq", {31'd0, irq0}, 32'd0);
    rd(0, 4'h0, 32'h0, "t2_clr_status");
    rd(0, 4'hC, 32'd2, "t2_clr_count");

    // unprivileged clear is ignored
    ev(32'h0000_0100, 0, 0, 0);
    wr(4'h0, 32'h1, 0);
    check("t3_irq", {31'd0, irq0}, 32'd1);
    rd(0, 4'h0, 32'h1, "t3_status");

    // clear and event in the same cycle: event wins
    ev(32'h0000_0200, 0, 0, 0);
    rd(0, 4'h0, 32'h3, "t4_pre_status");
    @(negedge clk);
    set_ev(32'h0001_0020, 0, 1, 1);
    reg_sel = 1; reg_we = 1; reg_off = 4'h0; reg_wdata = 32'h1; reg_priv = 1;
    step();
    check("t4_irq", {31'd0, irq0}, 32'd1);
    rd(0, 4'h0, 32'h1, "t4_status");
    rd(0, 4'h4, 32'h0001_0020, "t4_addr");
    rd(0, 4'h8, 32'h6, "t4_info");
    rd(0, 4'hC, 32'd5, "t4_count");

    // lockout at the 8th event
    ev(32'h0000_0300, 0, 0, 0);
    ev(32'h0000_0304, 0, 0, 0);
    check("t5_not_locked_7", {31'd0, lock0}, 32'd0);
    ev(32'h0000_0308, 0, 0, 0);
    check("t5_lockout", {31'd0, lock0}, 32'd1);
    rd(0, 4'h0, 32'h7, "t5_status");
    wr(4'h0, 32'h1, 1);
    check("t5_clr_lockout", {31'd0, lock0}, 32'd1);
    check("t5_clr_irq", {31'd0, irq0}, 32'd1);
    ev(32'h0000_0400, 1, 1, 1);
    rd(0, 4'h4, 32'h0001_0020, "t5_addr_frozen");
    rd(0, 4'hC, 32'd9, "t5_count");
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    check("t5_rst_lockout", {31'd0, lock0}, 32'd0);
    check("t5_rst_irq", {31'd0, irq0}, 32'd0);
    @(negedge clk); rst_n = 1;
    rd(0, 4'hC, 32'd0, "t5_rst_count");

    // saturation on the narrow, lockout-disabled instance
    do_reset();
    @(negedge clk);
    set_ev(32'h0000_0010, 0, 0, 0);
    reg_sel = 1; reg_we = 0; reg_off = 4'hC;
    step();
    check("t6_rd_pre_event", rdata1, 32'd0);
    rd(1, 4'hC, 32'd1, "t6_count1");
    for (int i = 0; i < 19; i++) ev(32'h0000_1000 + 32'(i), 0, 0, 0);
    rd(1, 4'hC, 32'd15, "t6_sat_count");
    check("t6_no_lockout", {31'd0, lock1}, 32'd0);
    @(negedge clk);
    acc_valid = 0; violation = 1;
    step();
    rd(1, 4'hC, 32'd15, "t6_invalid_ignored");
    wr(4'h0, 32'h1, 1);
    @(negedge clk);
    acc_valid = 0; violation = 1;
    step();
    check("t6_invalid_no_irq", {31'd0, irq1}, 32'd0);
    rd(1, 4'hC, 32'd15, "t6_count_final");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
